// File: rtl/sc_pkg.sv
// ---------------------------------------------------------------------------
// sc_pkg -- shared definitions for the serial register unloader.
//   sc_state_e         : controller states (IDLE, SHIFT, DONE, WAITREL)
//   DEF_DATAWIDTH_BUS  : default parallel word width
//   DEF_TICKDIV        : default clock cycles per serial bit
// ---------------------------------------------------------------------------
package sc_pkg;

  localparam int DEF_DATAWIDTH_BUS = 32'd8;
  localparam int DEF_TICKDIV       = 32'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    DONE    = 2'd2,
    WAITREL = 2'd3
  } sc_state_e;

endpackage

// File: rtl/sc_tick_counter.sv
// ---------------------------------------------------------------------------
// sc_tick_counter -- modulo-TICKDIV counter paced by the bit period.
//   clk_i     : clock, rising edge
//   rst_ni    : asynchronous active-low reset
//   restart_i : synchronous return to count 0 (wins over en_i)
//   en_i      : count enable
//   tick_o    : high for one cycle on the terminal count while enabled
// ---------------------------------------------------------------------------
module sc_tick_counter #(
  parameter int TICKDIV = 32'd4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic restart_i,
  input  logic en_i,
  output logic tick_o
);

  // A single-cycle period still needs a one-bit counter to stay legal.
  localparam int            CW   = (TICKDIV > 32'd1) ? $clog2(TICKDIV) : 32'd1;
  localparam logic [CW-1:0] TERM = CW'(TICKDIV - 32'd1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Terminal-count detection, only meaningful while counting.
  always_comb begin
    tick_o = en_i && (cnt_q == TERM);
  end

  // Next count: restart, wrap at the terminal count, or increment.
  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == TERM) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sc_reg_unloader.sv
// ---------------------------------------------------------------------------
// sc_reg_unloader -- unloads a parallel register word as a serial stream,
// MSB first, each bit held for TICKDIV clock cycles.
//   SC_REG_UNLOADER_CLOCK_50     : clock, rising edge
//   SC_REG_UNLOADER_RESET_InLow  : asynchronous active-low reset
//   SC_REG_UNLOADER_start_InLow  : active-low transfer request (sampled in IDLE)
//   SC_REG_UNLOADER_clear_InLow  : active-low synchronous abort, beats start
//   SC_REG_UNLOADER_data_InBUS   : parallel word captured on start
//   SC_REG_UNLOADER_serial_Out   : serial data
//   SC_REG_UNLOADER_valid_Out    : serial_Out carries a data/parity bit
//   SC_REG_UNLOADER_busy_Out     : transfer in progress
//   SC_REG_UNLOADER_done_OutLow  : one-cycle active-low completion pulse
// Build option: define SC_REG_UNLOADER_PARITY_EN to append one even-parity
// bit (XOR of the captured word) after the LSB.
// ---------------------------------------------------------------------------
module sc_reg_unloader
  import sc_pkg::*;
#(
  parameter int DATAWIDTH_BUS = DEF_DATAWIDTH_BUS,
  parameter int TICKDIV       = DEF_TICKDIV
) (
  input  logic                     SC_REG_UNLOADER_CLOCK_50,
  input  logic                     SC_REG_UNLOADER_RESET_InLow,
  input  logic                     SC_REG_UNLOADER_start_InLow,
  input  logic                     SC_REG_UNLOADER_clear_InLow,
  input  logic [DATAWIDTH_BUS-1:0] SC_REG_UNLOADER_data_InBUS,
  output logic                     SC_REG_UNLOADER_serial_Out,
  output logic                     SC_REG_UNLOADER_valid_Out,
  output logic                     SC_REG_UNLOADER_busy_Out,
  output logic                     SC_REG_UNLOADER_done_OutLow
);

  // Bit counter must reach DATAWIDTH_BUS (parity slot) without wrapping.
  localparam int BW = $clog2(DATAWIDTH_BUS + 32'd1);
`ifdef SC_REG_UNLOADER_PARITY_EN
  localparam logic [BW-1:0] LAST_BIT = BW'(DATAWIDTH_BUS);
  localparam logic [BW-1:0] PAR_BIT  = BW'(DATAWIDTH_BUS);
`else
  localparam logic [BW-1:0] LAST_BIT = BW'(DATAWIDTH_BUS - 32'd1);
`endif

  sc_state_e                state_q, state_d;
  logic [DATAWIDTH_BUS-1:0] shift_q, shift_d;
  logic [BW-1:0]            bit_cnt_q, bit_cnt_d;
  logic                     tick_s;
  logic                     tick_en_s;
  logic                     tick_restart_s;

`ifdef SC_REG_UNLOADER_PARITY_EN
  logic parity_q, parity_d;

  function automatic logic even_parity_f(input logic [DATAWIDTH_BUS-1:0] word);
    return ^word;
  endfunction
`endif

  // Tick counter runs only in SHIFT and sits at zero otherwise, so every
  // capture starts a fresh, full-length first bit period.
  always_comb begin
    tick_en_s      = (state_q == SHIFT);
    tick_restart_s = (state_q != SHIFT);
  end

  sc_tick_counter #(
    .TICKDIV (TICKDIV)
  ) u_tick (
    .clk_i     (SC_REG_UNLOADER_CLOCK_50),
    .rst_ni    (SC_REG_UNLOADER_RESET_InLow),
    .restart_i (tick_restart_s),
    .en_i      (tick_en_s),
    .tick_o    (tick_s)
  );

  // State, shift register, bit counter (and parity) registers.
  always_ff @(posedge SC_REG_UNLOADER_CLOCK_50 or negedge SC_REG_UNLOADER_RESET_InLow) begin
    if (!SC_REG_UNLOADER_RESET_InLow) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
`ifdef SC_REG_UNLOADER_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
`ifdef SC_REG_UNLOADER_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Next-state logic; clear overrides everything, including a pending start.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
`ifdef SC_REG_UNLOADER_PARITY_EN
    parity_d  = parity_q;
`endif
    if (!SC_REG_UNLOADER_clear_InLow) begin
      state_d = WAITREL;
    end else begin
      case (state_q)
        IDLE: begin
          if (!SC_REG_UNLOADER_start_InLow) begin
            shift_d   = SC_REG_UNLOADER_data_InBUS;
            bit_cnt_d = '0;
`ifdef SC_REG_UNLOADER_PARITY_EN
            parity_d  = even_parity_f(SC_REG_UNLOADER_data_InBUS);
`endif
            state_d   = SHIFT;
          end else begin
            state_d = IDLE;
          end
        end
        SHIFT: begin
          if (tick_s) begin
            if (bit_cnt_q == LAST_BIT) begin
              state_d = DONE;
            end else begin
              shift_d   = shift_q << 1;
              bit_cnt_d = bit_cnt_q + BW'(1);
            end
          end else begin
            state_d = SHIFT;
          end
        end
        DONE: begin
          state_d = WAITREL;
        end
        WAITREL: begin
          // A start held low across the whole transfer must not retrigger.
          if (SC_REG_UNLOADER_start_InLow) begin
            state_d = IDLE;
          end else begin
            state_d = WAITREL;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    SC_REG_UNLOADER_serial_Out  = 1'b0;
    SC_REG_UNLOADER_valid_Out   = 1'b0;
    SC_REG_UNLOADER_busy_Out    = 1'b0;
    SC_REG_UNLOADER_done_OutLow = 1'b1;
    case (state_q)
      SHIFT: begin
        SC_REG_UNLOADER_valid_Out = 1'b1;
        SC_REG_UNLOADER_busy_Out  = 1'b1;
`ifdef SC_REG_UNLOADER_PARITY_EN
        if (bit_cnt_q == PAR_BIT) begin
          SC_REG_UNLOADER_serial_Out = parity_q;
        end else begin
          SC_REG_UNLOADER_serial_Out = shift_q[DATAWIDTH_BUS-1];
        end
`else
        SC_REG_UNLOADER_serial_Out = shift_q[DATAWIDTH_BUS-1];
`endif
      end
      DONE: begin
        SC_REG_UNLOADER_done_OutLow = 1'b0;
      end
      default: begin
        SC_REG_UNLOADER_done_OutLow = 1'b1;
      end
    endcase
  end

endmodule
